// File: rtl/feedback_arbiter.sv
// Round-robin owner of a shared feedback accumulator: grants one requester at a
// time, clears the adder, gates the burst onto acc_din and captures the final sum.
module feedback_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 16,
  parameter int LEN_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  input  logic [NREQ*W-1:0]       req_data,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         gnt,
  output logic [W-1:0]            acc_din,
  output logic                    acc_rst,
  input  logic [W-1:0]            acc_dout,
  output logic [W-1:0]            result,
  output logic [$clog2(NREQ)-1:0] result_id,
  output logic                    done
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     result_q, result_d;
  logic [IDW-1:0]   result_id_q, result_id_d;

  logic [W-1:0]     lane_data [NREQ];
  logic [LEN_W-1:0] lane_len  [NREQ];

  logic             pick_vld;
  logic [IDW-1:0]   pick_id;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      lane_data[i] = req_data[i*W +: W];
      lane_len[i]  = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Scan offsets from farthest to nearest so the first set bit after rr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(rr_q) + k) % NREQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_id_d = result_id_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_id;
          len_d   = lane_len[pick_id];
          rr_d    = pick_id;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = (len_q == '0) ? DRAIN : ACCUM;
      end
      ACCUM: begin
        // Dropping req aborts even if a word is presented on the same edge.
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else if (req_valid[owner_q]) begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      DRAIN: begin
        result_d    = acc_dout;
        result_id_d = owner_q;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_q        <= IDW'(NREQ - 1);
      len_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_id_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == ACCUM) begin
      gnt[owner_q] = 1'b1;
    end
  end

  always_comb begin
    acc_din = '0;
    if (state_q == ACCUM && req_valid[owner_q]) begin
      acc_din = lane_data[owner_q];
    end
  end

  assign acc_rst   = (state_q == IDLE) || (state_q == CLEAR) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign result_id = result_id_q;

endmodule
